// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code lock that gates the AC motor enable, with retry lockout and 7-segment status
// Ports: clk, rst_n (async active-low); key_valid/key_in digit strobe; clear aborts entry or closes the open window;
//        prog/prog_code load a new code while open; motor_on, outscreen (4 digits x 7 segments, active low),
//        locked_out, tries_left.
// Build option: define CODE_PROG_EN to make the code reprogrammable; otherwise the code is the constant CODE.
module code_lock_ctrl #(
  parameter int DIGIT_W = 5,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 20'h3CD75,
  parameter int MAX_TRIES = 3,
  parameter int OPEN_CYCLES = 50000000,
  parameter int DENY_CYCLES = 25000000,
  parameter int LOCKOUT_CYCLES = 250000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_in,
  input  logic                        clear,
  input  logic                        prog,
  input  logic [CODE_LEN*DIGIT_W-1:0] prog_code,
  output logic                        motor_on,
  output logic [27:0]                 outscreen,
  output logic                        locked_out,
  output logic [3:0]                  tries_left
);
  localparam int MAX_CYC = OPEN_CYCLES > DENY_CYCLES ?
                           (OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES) :
                           (DENY_CYCLES > LOCKOUT_CYCLES ? DENY_CYCLES : LOCKOUT_CYCLES);
  localparam int TW = $clog2(MAX_CYC + 1);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int PW = CODE_LEN * DIGIT_W;
  localparam logic [27:0] SEG_BLANK = 28'hFFFFFFF;
  localparam logic [27:0] SEG_OPEN  = 28'h1820912;
  localparam logic [27:0] SEG_DENY  = 28'h1C23CC7;
  localparam logic [27:0] SEG_LOCK  = 28'h0000000;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, DENY, LOCKOUT} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic miss, miss_n;
  logic [3:0] tries_n, tries_dec;
  logic [PW-1:0] code_q;
  logic [DIGIT_W-1:0] code_dig;
  logic prog_hit;
`ifdef CODE_PROG_EN
  assign prog_hit = (state == OPEN) && prog;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) code_q <= CODE;
    else if (prog_hit) code_q <= prog_code;
`else
  logic unused_prog;
  assign prog_hit = 1'b0;
  assign code_q = CODE;
  assign unused_prog = &{1'b0, prog, prog_code};
`endif
  assign cnt_inc = cnt + CW'(1);
  assign tries_dec = tries_left - 4'd1;
  // digits arrive in order, so the count selects which stored digit to compare against
  assign code_dig = DIGIT_W'(code_q >> (32'(cnt) * DIGIT_W));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    miss_n = miss;
    tries_n = tries_left;
    case (state)
      IDLE, ENTRY:
        if (state == ENTRY && clear) begin
          state_n = IDLE;
          cnt_n = '0;
          miss_n = 1'b0;
        end else if (key_valid) begin
          cnt_n = cnt_inc;
          miss_n = miss | (key_in != code_dig);
          state_n = cnt_inc == CW'(CODE_LEN) ? CHECK : ENTRY;
        end
      CHECK: begin
        cnt_n = '0;
        miss_n = 1'b0;
        tries_n = miss ? tries_dec : 4'(MAX_TRIES);
        state_n = !miss ? OPEN : tries_dec == 4'd0 ? LOCKOUT : DENY;
      end
      OPEN: state_n = prog_hit || clear || tmr == '0 ? IDLE : OPEN;
      DENY: state_n = tmr == '0 ? IDLE : DENY;
      LOCKOUT: begin
        state_n = tmr == '0 ? IDLE : LOCKOUT;
        tries_n = tmr == '0 ? 4'(MAX_TRIES) : tries_left;
      end
      default: state_n = IDLE;
    endcase
    // load N-1 on entry to a timed state so the state lasts exactly N clocks
    tmr_n = state_n == state ? (tmr != '0 ? tmr - TW'(1) : '0) :
            state_n == OPEN ? TW'(OPEN_CYCLES - 1) :
            state_n == DENY ? TW'(DENY_CYCLES - 1) :
            state_n == LOCKOUT ? TW'(LOCKOUT_CYCLES - 1) : '0;
  end
  // outputs register the decode of the next state, so they track the state register exactly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      miss <= 1'b0;
      tries_left <= 4'(MAX_TRIES);
      motor_on <= 1'b0;
      locked_out <= 1'b0;
      outscreen <= SEG_BLANK;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      cnt <= cnt_n;
      miss <= miss_n;
      tries_left <= tries_n;
      motor_on <= state_n == OPEN;
      locked_out <= state_n == LOCKOUT;
      outscreen <= state_n == OPEN ? SEG_OPEN : state_n == DENY ? SEG_DENY :
                   state_n == LOCKOUT ? SEG_LOCK : SEG_BLANK;
    end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed checks of code_lock_ctrl with short timed windows
module tb_code_lock_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, key_valid = 1'b0, clear = 1'b0, prog = 1'b0;
  logic [4:0] key_in = '0;
  logic [19:0] prog_code = '0;
  logic motor_on, locked_out;
  logic [27:0] outscreen;
  logic [3:0] tries_left;
  logic [33:0] obs, exp;
  int checks = 0, errors = 0;
  localparam logic [27:0] BLANK = 28'hFFFFFFF, OPEN_P = 28'h1820912, DENY_P = 28'h1C23CC7, LOCK_P = 28'h0000000;
  localparam logic [19:0] GOOD = 20'h3CD75, BAD = 20'h04D75;
  code_lock_ctrl #(.OPEN_CYCLES(8), .DENY_CYCLES(4), .LOCKOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in), .clear(clear),
    .prog(prog), .prog_code(prog_code), .motor_on(motor_on), .outscreen(outscreen),
    .locked_out(locked_out), .tries_left(tries_left)
  );
  assign obs = {motor_on, locked_out, tries_left, outscreen};
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task key(input logic [4:0] d);
    key_valid = 1'b1;
    key_in = d;
    tick();
    key_valid = 1'b0;
  endtask
  task enter(input logic [19:0] c);
    logic [19:0] v;
    v = c;
    for (int i = 0; i < 4; i++) key(v[i*5 +: 5]);
  endtask
  task test_reset;
    #3 rst_n = 1'b0;
    #4;
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset got %h exp %h", obs, exp); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask
  task test_open;
    enter(GOOD);
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL open_check got %h exp %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {1'b1, 1'b0, 4'd3, OPEN_P};
      checks++; if (obs !== exp) begin errors++; $display("FAIL open_cyc%0d got %h exp %h", i, obs, exp); end
    end
    tick();
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL open_end got %h exp %h", obs, exp); end
  endtask
  task test_deny;
    enter(BAD);
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL deny_check got %h exp %h", obs, exp); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b0, 1'b0, 4'd2, DENY_P};
      checks++; if (obs !== exp) begin errors++; $display("FAIL deny_cyc%0d got %h exp %h", i, obs, exp); end
    end
    tick();
    exp = {1'b0, 1'b0, 4'd2, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL deny_end got %h exp %h", obs, exp); end
  endtask
  task test_lockout;
    enter(BAD);
    tick();
    exp = {1'b0, 1'b0, 4'd1, DENY_P};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lock_deny2 got %h exp %h", obs, exp); end
    repeat (4) tick();
    enter(BAD);
    for (int i = 0; i < 16; i++) begin
      key_valid = i < 6;
      key_in = 5'h15;
      tick();
      exp = {1'b0, 1'b1, 4'd0, LOCK_P};
      checks++; if (obs !== exp) begin errors++; $display("FAIL lock_cyc%0d got %h exp %h", i, obs, exp); end
    end
    key_valid = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lock_end got %h exp %h", obs, exp); end
  endtask
  task test_abort;
    enter(BAD);
    repeat (5) tick();
    key(5'h15);
    key(5'h0B);
    clear = 1'b1;
    key_valid = 1'b1;
    key_in = 5'h13;
    tick();
    clear = 1'b0;
    key_valid = 1'b0;
    exp = {1'b0, 1'b0, 4'd2, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL abort_idle got %h exp %h", obs, exp); end
    enter(GOOD);
    tick();
    exp = {1'b1, 1'b0, 4'd3, OPEN_P};
    checks++; if (obs !== exp) begin errors++; $display("FAIL abort_reopen got %h exp %h", obs, exp); end
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL clear_close got %h exp %h", obs, exp); end
  endtask
  task test_reset_mid;
    enter(GOOD);
    repeat (3) tick();
    exp = {1'b1, 1'b0, 4'd3, OPEN_P};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rstmid_open got %h exp %h", obs, exp); end
    #2 rst_n = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rstmid_async got %h exp %h", obs, exp); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (obs !== exp) begin errors++; $display("FAIL rstmid_after got %h exp %h", obs, exp); end
  endtask
`ifdef CODE_PROG_EN
  task test_prog;
    enter(GOOD);
    tick();
    exp = {1'b1, 1'b0, 4'd3, OPEN_P};
    checks++; if (obs !== exp) begin errors++; $display("FAIL prog_open got %h exp %h", obs, exp); end
    prog = 1'b1;
    prog_code = 20'h00001;
    tick();
    prog = 1'b0;
    exp = {1'b0, 1'b0, 4'd3, BLANK};
    checks++; if (obs !== exp) begin errors++; $display("FAIL prog_idle got %h exp %h", obs, exp); end
    enter(GOOD);
    tick();
    exp = {1'b0, 1'b0, 4'd2, DENY_P};
    checks++; if (obs !== exp) begin errors++; $display("FAIL prog_olddeny got %h exp %h", obs, exp); end
    repeat (4) tick();
    enter(20'h00001);
    tick();
    exp = {1'b1, 1'b0, 4'd3, OPEN_P};
    checks++; if (obs !== exp) begin errors++; $display("FAIL prog_newopen got %h exp %h", obs, exp); end
  endtask
`endif
  initial begin
    test_reset();
    test_open();
    test_deny();
    test_lockout();
    test_abort();
    test_reset_mid();
`ifdef CODE_PROG_EN
    test_prog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
